f1_start_ctrl: RTL and testbench
================================

// Module: f1_start_ctrl
// PURPOSE
//  Sequences a full F1 race start and times the driver's reaction.
//  - Builds the 8-light gantry one light per step.
//  - Holds all lights on for a pseudo-random delay, then switches them off.
//  - Measures the reaction time to a button press, in ms ticks.
//  - Sits between the board button/trigger inputs and the LED bar and 7-seg display.
// PARAMETERS
//  LIGHT_CYCLES  1000  clk cycles per light step; also the hold-delay unit (>=2)
//  MS_CYCLES     10    clk cycles per reaction-time count (>=2)
//  RT_W          16    width of the reaction-time result
// PORTS
//  clk          in   1      system clock, all logic on rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  trigger      in   1      start request, synchronous; level sampled each cycle
//  react        in   1      driver button, synchronous level; rising edge detected internally
//  lights       out  8      gantry pattern, LSB = first light
//  busy         out  1      1 in LIGHTS, HOLD, TIMING
//  rt_valid     out  1      one-cycle pulse when rt_ms is updated
//  rt_ms        out  RT_W   last reaction time in MS_CYCLES units; holds until next start
//  false_start  out  1      sticky: react edge before lights-out; cleared by next accepted trigger
// BEHAVIOUR
//  Reset values: lights=0, busy=0, rt_valid=0, rt_ms=0, false_start=0, state=IDLE.
//  Internal reset values: lfsr=7'h01, react_q=0, counters=0.
//  - LFSR: 7-bit Fibonacci, x^7+x^6+1; advances every cycle in all states. Never all-zero.
//  - react_edge = react & ~react_q; react_q registered every cycle.
//  - Tick counter: counts LIGHT_CYCLES or MS_CYCLES by state; cleared on every state entry.
//  States:
//   IDLE
//    - lights=0.
//    - trigger=1 -> LIGHTS; clears false_start and rt_ms.
//    - react ignored.
//   LIGHTS
//    - Each LIGHT_CYCLES expiry: lights <= {lights[6:0],1'b1}.
//    - First light appears LIGHT_CYCLES cycles after the trigger cycle.
//    - On the expiry that makes lights=8'hFF: capture hold_n = lfsr[3:0]+1 (range 1..16) -> HOLD.
//   HOLD
//    - lights=8'hFF; wait hold_n light steps.
//    - On the last expiry: lights <= 0 -> TIMING; rt counter=0.
//   TIMING
//    - rt counter +1 on each MS_CYCLES expiry.
//    - react_edge -> DONE: rt_ms <= count, rt_valid=1 for exactly 1 cycle.
//    - Counter reaching all-ones saturates -> DONE with rt_ms = all-ones (timeout).
//   DONE
//    - Single-cycle state -> IDLE.
//  False start:
//   - react_edge in LIGHTS or HOLD -> IDLE immediately (next cycle): lights=0, false_start=1.
//   - rt_valid not pulsed; rt_ms stays 0.
//  Simultaneous events:
//   - trigger while busy or in DONE: ignored.
//   - react_edge and a tick expiry in the same cycle: react wins (false start, or capture of the pre-increment count).
//   - react held high from before the start: no edge, so no false start.
//  rst_n asserted mid-sequence: all outputs return to reset values asynchronously; no rt_valid.
// STRUCTURE
//  Package f1_pkg:
//   - state enum (IDLE, LIGHTS, HOLD, TIMING, DONE)
//   - LFSR taps/seed constants
//   - LIGHTS_FULL = 8'hFF
//  Sub-module f1_lfsr7:
//   - Free-running 7-bit LFSR.
//   - Ports clk, rst_n, q[6:0].
//  Tick counter and state machine live in this module.
// TESTING (LIGHT_CYCLES=4, MS_CYCLES=2, RT_W=8)
//  1. Reset, trigger pulse at cycle 0
//     -> lights 01,03,..,FF at cycles 4,8,..,32; busy=1 from cycle 1.
//  2. Continue test 1
//     -> lights=FF for (lfsr[3:0]+1)*4 cycles (bench LFSR model), then 00; react edge 10 cycles later
//     -> rt_valid pulse, rt_ms=5.
//  3. react edge while lights=07
//     -> next cycle lights=00, false_start=1, busy=0, no rt_valid; a new trigger clears false_start.
//  4. No react after lights-out
//     -> rt_ms=8'hFF after 255*2 cycles, single rt_valid pulse, return to IDLE.
//  5. trigger re-pulsed during LIGHTS and TIMING
//     -> sequence unaffected; react held high across trigger -> no false start.
//  6. rst_n low while lights=1F
//     -> lights=0, busy=0 immediately; LFSR=01; next trigger restarts from test 1 timing.

Source files
------------

// File: rtl/f1_pkg.sv
// Shared types and constants for the F1 start-light controller.
// Holds the FSM state type, LFSR constants and the LFSR step function.
package f1_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StLights,
      StHold,
      StTiming,
      StDone
   } state_e;

   localparam logic [6:0] LfsrSeed   = 7'h01;
   // x^7 + x^6 + 1: feedback from bits 6 and 5
   localparam logic [6:0] LfsrTaps   = 7'h60;
   localparam logic [7:0] LightsFull = 8'hFF;

   function automatic logic [6:0] lfsr_next(input logic [6:0] cur);
      return {cur[5:0], ^(cur & LfsrTaps)};
   endfunction

endpackage

// File: rtl/f1_lfsr7.sv
// Free-running 7-bit Fibonacci LFSR used to randomise the all-lights-on hold time.
// Leaves reset at the non-zero seed, so it can never lock up at all-zero.
module f1_lfsr7
   import f1_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   output logic [6:0] q
);

   logic [6:0] q_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q <= LfsrSeed;
      end else begin
         q_q <= lfsr_next(q_q);
      end
   end

   assign q = q_q;

endmodule

// File: rtl/f1_start_ctrl.sv
// F1 start sequencer: builds the 8-light gantry, holds for a random delay,
// switches the lights off and measures the driver's reaction time in ms ticks.
module f1_start_ctrl
   import f1_pkg::*;
#(
   parameter int unsigned LIGHT_CYCLES = 1000,
   parameter int unsigned MS_CYCLES    = 10,
   parameter int unsigned RT_W         = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            trigger,
   input  logic            react,
   output logic [7:0]      lights,
   output logic            busy,
   output logic            rt_valid,
   output logic [RT_W-1:0] rt_ms,
   output logic            false_start
);

   localparam int unsigned TickMax = (LIGHT_CYCLES > MS_CYCLES) ? LIGHT_CYCLES : MS_CYCLES;
   localparam int unsigned TickW   = $clog2(TickMax);

   state_e            state_q;
   logic [TickW-1:0]  tick_q;
   logic [4:0]        hold_q;
   logic [RT_W-1:0]   rt_cnt_q;
   logic [7:0]        lights_q;
   logic              busy_q;
   logic              rt_valid_q;
   logic [RT_W-1:0]   rt_ms_q;
   logic              false_start_q;
   logic              react_q;

   logic [6:0]        lfsr;
   logic              unused_lfsr;
   logic              react_edge;
   logic              tick_done;
   logic [RT_W-1:0]   rt_inc;
   logic [7:0]        lights_shift;

   f1_lfsr7 u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .q     (lfsr)
   );

   assign unused_lfsr = ^lfsr[6:4];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         react_q <= 1'b0;
      end else begin
         react_q <= react;
      end
   end

   always_comb begin
      react_edge   = react & ~react_q;
      rt_inc       = rt_cnt_q + RT_W'(1);
      lights_shift = {lights_q[6:0], 1'b1};
      if (state_q == StTiming) begin
         tick_done = (tick_q == TickW'(MS_CYCLES - 1));
      end else begin
         tick_done = (tick_q == TickW'(LIGHT_CYCLES - 1));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         tick_q        <= '0;
         hold_q        <= '0;
         rt_cnt_q      <= '0;
         lights_q      <= '0;
         busy_q        <= 1'b0;
         rt_valid_q    <= 1'b0;
         rt_ms_q       <= '0;
         false_start_q <= 1'b0;
      end else begin
         rt_valid_q <= 1'b0;
         tick_q     <= tick_q + TickW'(1);
         unique case (state_q)
            StIdle: begin
               lights_q <= '0;
               tick_q   <= '0;
               if (trigger) begin
                  state_q       <= StLights;
                  busy_q        <= 1'b1;
                  false_start_q <= 1'b0;
                  rt_ms_q       <= '0;
                  // The trigger cycle itself is the first tick of the first light step
                  tick_q        <= TickW'(1);
               end
            end

            StLights: begin
               if (react_edge) begin
                  state_q       <= StIdle;
                  lights_q      <= '0;
                  busy_q        <= 1'b0;
                  false_start_q <= 1'b1;
                  tick_q        <= '0;
               end else if (tick_done) begin
                  tick_q   <= '0;
                  lights_q <= lights_shift;
                  if (lights_shift == LightsFull) begin
                     hold_q  <= {1'b0, lfsr[3:0]} + 5'd1;
                     state_q <= StHold;
                  end
               end
            end

            StHold: begin
               if (react_edge) begin
                  state_q       <= StIdle;
                  lights_q      <= '0;
                  busy_q        <= 1'b0;
                  false_start_q <= 1'b1;
                  tick_q        <= '0;
               end else if (tick_done) begin
                  tick_q <= '0;
                  if (hold_q == 5'd1) begin
                     lights_q <= '0;
                     rt_cnt_q <= '0;
                     state_q  <= StTiming;
                  end else begin
                     hold_q <= hold_q - 5'd1;
                  end
               end
            end

            StTiming: begin
               // A press in an expiry cycle wins and reports the pre-increment count
               if (react_edge) begin
                  rt_ms_q    <= rt_cnt_q;
                  rt_valid_q <= 1'b1;
                  busy_q     <= 1'b0;
                  tick_q     <= '0;
                  state_q    <= StDone;
               end else if (tick_done) begin
                  tick_q <= '0;
                  if (&rt_inc) begin
                     rt_ms_q    <= rt_inc;
                     rt_valid_q <= 1'b1;
                     busy_q     <= 1'b0;
                     state_q    <= StDone;
                  end else begin
                     rt_cnt_q <= rt_inc;
                  end
               end
            end

            StDone: begin
               tick_q  <= '0;
               state_q <= StIdle;
            end

            default: begin
               tick_q  <= '0;
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign lights      = lights_q;
   assign busy        = busy_q;
   assign rt_valid    = rt_valid_q;
   assign rt_ms       = rt_ms_q;
   assign false_start = false_start_q;

endmodule

// File: tb/tb_f1_start_ctrl.sv
// Scoreboard bench for f1_start_ctrl: stimulus pushes expected reaction times,
// a negedge monitor pops them whenever rt_valid is seen.
module tb_f1_start_ctrl;

   localparam int unsigned LC = 4;
   localparam int unsigned MC = 2;
   localparam int unsigned RW = 8;

   logic          clk     = 1'b0;
   logic          rst_n   = 1'b0;
   logic          trigger = 1'b0;
   logic          react   = 1'b0;
   logic [7:0]    lights;
   logic          busy;
   logic          rt_valid;
   logic [RW-1:0] rt_ms;
   logic          false_start;

   int            n_checks = 0;
   int            n_fail   = 0;
   logic [7:0]    exp_q[$];
   logic [7:0]    e_ms;
   logic [6:0]    m_lfsr;
   logic [6:0]    m_lfsr_prev;
   int            hold;

   f1_start_ctrl #(
      .LIGHT_CYCLES (LC),
      .MS_CYCLES    (MC),
      .RT_W         (RW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .trigger     (trigger),
      .react       (react),
      .lights      (lights),
      .busy        (busy),
      .rt_valid    (rt_valid),
      .rt_ms       (rt_ms),
      .false_start (false_start)
   );

   always #5 clk = ~clk;

   // Reference LFSR: x^7 + x^6 + 1, seed 1; prev holds the value of the previous cycle
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_lfsr      <= 7'h01;
         m_lfsr_prev <= 7'h01;
      end else begin
         m_lfsr_prev <= m_lfsr;
         m_lfsr      <= {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rt_valid) begin
         if (exp_q.size() == 0) begin
            check("rt_valid_unexpected", 1, 0);
         end else begin
            e_ms = exp_q.pop_front();
            check("rt_ms_on_valid", int'(rt_ms), int'(e_ms));
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Called in cycle 0; returns in cycle stop_c. retrig re-pulses trigger in that cycle.
   task automatic run_start(input int retrig, input int stop_c, output int h);
      logic [8:0] pat;
      trigger = 1'b1;
      step(1);
      trigger = 1'b0;
      check("busy_cycle1", busy, 1);
      check("false_start_cleared", false_start, 0);
      check("rt_ms_cleared", int'(rt_ms), 0);
      for (int c = 1; c < stop_c; c++) begin
         trigger = (c == retrig);
         step(1);
         trigger = 1'b0;
         if (c + 1 == 3) check("no_early_light", int'(lights), 0);
         if ((c + 1) % 4 == 0) begin
            pat = (9'd1 << ((c + 1) / 4)) - 9'd1;
            check("light_step", int'(lights), int'(pat[7:0]));
         end
      end
      h = int'(m_lfsr_prev[3:0]) + 1;
   endtask

   // Called in cycle 32; returns in the lights-out cycle
   task automatic run_hold(input int h);
      step(4 * h - 1);
      check("hold_last_ff", int'(lights), 8'hFF);
      step(1);
      check("lights_out", int'(lights), 0);
      check("busy_timing", busy, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      step(3);
      check("rst_lights", int'(lights), 0);
      check("rst_busy", busy, 0);
      check("rst_rt_valid", rt_valid, 0);
      check("rst_rt_ms", int'(rt_ms), 0);
      check("rst_false_start", false_start, 0);
      rst_n = 1'b1;

      // Full sequence, react 10 cycles after lights-out
      run_start(0, 32, hold);
      run_hold(hold);
      step(10);
      react = 1'b1;
      exp_q.push_back(8'd5);
      step(2);
      check("busy_after_done", busy, 0);
      check("rt_ms_held", int'(rt_ms), 5);
      react = 1'b0;
      step(3);

      // False start while lights = 07
      run_start(0, 12, hold);
      check("lights_07", int'(lights), 8'h07);
      react = 1'b1;
      step(1);
      check("fs_lights", int'(lights), 0);
      check("fs_flag", false_start, 1);
      check("fs_busy", busy, 0);
      check("fs_rt_ms", int'(rt_ms), 0);
      react = 1'b0;
      step(3);
      check("fs_sticky", false_start, 1);

      // No reaction: saturating timeout
      run_start(0, 32, hold);
      run_hold(hold);
      exp_q.push_back(8'hFF);
      step(509);
      check("timeout_not_yet", busy, 1);
      step(1);
      check("timeout_busy", busy, 0);
      step(1);
      check("timeout_rt_ms", int'(rt_ms), 8'hFF);
      check("timeout_single_pulse", rt_valid, 0);
      step(3);

      // React held across trigger, re-triggers in LIGHTS and TIMING, react on an expiry cycle
      react = 1'b1;
      step(2);
      run_start(10, 32, hold);
      check("held_no_false_start", false_start, 0);
      run_hold(hold);
      step(3);
      trigger = 1'b1;
      step(1);
      trigger = 1'b0;
      check("retrig_timing_busy", busy, 1);
      check("retrig_timing_lights", int'(lights), 0);
      step(1);
      react = 1'b0;
      step(4);
      react = 1'b1;
      exp_q.push_back(8'd4);
      step(2);
      check("tie_busy", busy, 0);
      react = 1'b0;
      step(3);

      // Reset while lights = 1F, then restart
      run_start(0, 20, hold);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_lights", int'(lights), 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_lfsr", int'(dut.u_lfsr.q), 1);
      step(2);
      rst_n = 1'b1;
      run_start(0, 32, hold);
      run_hold(hold);
      step(10);
      react = 1'b1;
      exp_q.push_back(8'd5);
      step(2);
      react = 1'b0;
      step(4);

      check("scoreboard_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
